// File: rtl/isp_program_loader_if.sv
// Byte-stream and program-memory/boot bundle for isp_program_loader.
// slave = loader side, master = byte source / core side.
interface isp_program_loader_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    rx_ready;
    logic                    isp_write;
    logic [ADDRESS_BITS-1:0] isp_address;
    logic [DATA_WIDTH-1:0]   isp_data;
    logic                    core_reset;
    logic                    start;
    logic [19:0]             prog_address;
    logic                    busy;
    logic                    done;
    logic                    error;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, isp_write, isp_address, isp_data,
        output core_reset, start, prog_address,
        output busy, done, error
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, isp_write, isp_address, isp_data,
        input  core_reset, start, prog_address,
        input  busy, done, error
    );
endinterface

// File: rtl/isp_program_loader.sv
// Framed byte-stream boot loader: writes 32-bit words over ISP,
// then releases the core from reset and pulses start.
module isp_program_loader #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDRESS_BITS = 12,
    parameter int          BASE_ADDR    = 0,
    parameter logic [19:0] START_ADDR   = 20'h00000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input logic           clock,
    input logic           reset,
    isp_program_loader_if.slave bus
);
    localparam logic [16:0] MAX_WORDS =
        17'((1 << ADDRESS_BITS) - BASE_ADDR);
    localparam logic [ADDRESS_BITS-1:0] BASE_W =
        ADDRESS_BITS'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, PAYLOAD, CHECK, START, ERR
    } state_t;

    state_t      state, state_next;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  checksum;
    logic        accept;
    logic        sync_hit;
    logic        word_last;
    logic [15:0] count_full;
    logic        too_big;

    assign bus.rx_ready = (state != START);
    assign bus.start    = (state == START);

    always_comb begin
        accept     = bus.rx_valid && bus.rx_ready;
        sync_hit   = accept && (bus.rx_data == SYNC_BYTE)
                     && (state == IDLE || state == ERR);
        word_last  = (word_idx + 16'd1 == count);
        count_full = {bus.rx_data, count[7:0]};
        too_big    = {1'b0, count_full} > MAX_WORDS;
        state_next = state;
        unique case (state)
            IDLE, ERR: begin
                if (sync_hit) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (accept) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (accept) begin
                    if (too_big)              state_next = ERR;
                    else if (count_full == 0) state_next = CHECK;
                    else                      state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept && byte_idx == 2'd3 && word_last)
                    state_next = CHECK;
            end
            CHECK: begin
                if (accept)
                    state_next = (bus.rx_data == checksum) ? START : ERR;
            end
            START:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count            <= '0;
            word_idx         <= '0;
            byte_idx         <= '0;
            word_buf         <= '0;
            checksum         <= '0;
            bus.isp_write    <= 1'b0;
            bus.isp_address  <= '0;
            bus.isp_data     <= '0;
            bus.core_reset   <= 1'b1;
            bus.prog_address <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            bus.isp_write <= 1'b0;
            if (sync_hit) begin
                bus.busy       <= 1'b1;
                bus.done       <= 1'b0;
                bus.error      <= 1'b0;
                bus.core_reset <= 1'b1;
                checksum       <= '0;
                word_idx       <= '0;
                byte_idx       <= '0;
            end
            if (accept && state == CNT_LO)
                count[7:0] <= bus.rx_data;
            if (accept && state == CNT_HI) begin
                count[15:8] <= bus.rx_data;
                if (too_big) begin
                    bus.error <= 1'b1;
                    bus.busy  <= 1'b0;
                end
            end
            if (accept && state == PAYLOAD) begin
                checksum <= checksum + bus.rx_data;
                byte_idx <= byte_idx + 2'd1;
                unique case (byte_idx)
                    2'd0: word_buf[7:0]   <= bus.rx_data;
                    2'd1: word_buf[15:8]  <= bus.rx_data;
                    2'd2: word_buf[23:16] <= bus.rx_data;
                    default: begin
                        bus.isp_write   <= 1'b1;
                        bus.isp_data    <= {bus.rx_data, word_buf};
                        bus.isp_address <= BASE_W
                                         + word_idx[ADDRESS_BITS-1:0];
                        word_idx        <= word_idx + 16'd1;
                    end
                endcase
            end
            if (accept && state == CHECK) begin
                if (bus.rx_data == checksum) begin
                    bus.core_reset   <= 1'b0;
                    bus.prog_address <= START_ADDR;
                end else begin
                    bus.error <= 1'b1;
                    bus.busy  <= 1'b0;
                end
            end
            if (state == START) begin
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_isp_program_loader.sv
// Directed bench for isp_program_loader: framing, checksum, errors,
// stalls, garbage and mid-frame reset against hand-computed values.
module tb_isp_program_loader;
    localparam logic [19:0] TB_START = 20'h00ABC;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   start_cnt;
    int   base;
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  good[$];
    logic [7:0]  bad[$];
    logic [7:0]  part[$];

    isp_program_loader_if bus ();

    isp_program_loader #(
        .START_ADDR(TB_START)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clock);
        #1;
        if (bus.isp_write) begin
            wa.push_back(bus.isp_address);
            wd.push_back(bus.isp_data);
        end
        if (bus.start) begin
            start_cnt++;
            check("start_addr", 32'(bus.prog_address), 32'(TB_START));
        end
    end

    task automatic idle();
        @(negedge clock);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) idle();
        @(negedge clock);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (!bus.rx_ready) check("rx_ready_timeout", 0, 1);
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input bit gaps);
        foreach (q[i]) send_byte(q[i], gaps);
    endtask

    task automatic check_writes(input string tag, input int from,
                                input int n);
        logic [31:0] img [2];
        img[0] = 32'h0000_0013;
        img[1] = 32'h0000_006F;
        check({tag, "_cnt"}, 32'(wa.size() - from), 32'(n));
        for (int i = 0; i < n && from + i < wa.size(); i++) begin
            check({tag, "_addr"}, 32'(wa[from+i]), 32'(i));
            check({tag, "_data"}, wd[from+i], img[i]);
        end
    endtask

    task automatic check_boot(input string tag);
        idle();
        check({tag, "_start"}, 32'(bus.start), 1);
        check({tag, "_corerst_lo"}, 32'(bus.core_reset), 0);
        check({tag, "_ready_lo"}, 32'(bus.rx_ready), 0);
        idle();
        check({tag, "_start_end"}, 32'(bus.start), 0);
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_err"}, 32'(bus.error), 0);
        check({tag, "_corerst"}, 32'(bus.core_reset), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, 32'(bus.core_reset), 1);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 1);
        check({tag, "_isp_write"}, 32'(bus.isp_write), 0);
        check({tag, "_isp_address"}, 32'(bus.isp_address), 0);
        check({tag, "_isp_data"}, bus.isp_data, 0);
        check({tag, "_start"}, 32'(bus.start), 0);
        check({tag, "_prog_address"}, 32'(bus.prog_address), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_error"}, 32'(bus.error), 0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        start_cnt    = 0;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        bad  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
        part = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00};
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_vals("rst");

        // Directed frame with write-latency probe on word 0
        base = wa.size();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 0);
        idle();
        check("w0_strobe", 32'(bus.isp_write), 1);
        check("w0_addr", 32'(bus.isp_address), 0);
        check("w0_data", bus.isp_data, 32'h13);
        check("w0_busy", 32'(bus.busy), 1);
        idle();
        check("w0_single", 32'(bus.isp_write), 0);
        send_bytes('{8'h6F, 8'h00, 8'h00, 8'h00, 8'h82}, 0);
        check_boot("boot1");
        check_writes("f1", base, 2);
        check("f1_starts", 32'(start_cnt), 1);

        // Bad checksum, then recovery
        base = wa.size();
        send_bytes(bad, 0);
        idle();
        check("bad_err", 32'(bus.error), 1);
        check("bad_corerst", 32'(bus.core_reset), 1);
        check("bad_busy", 32'(bus.busy), 0);
        check("bad_done", 32'(bus.done), 0);
        repeat (3) idle();
        check("bad_nostart", 32'(start_cnt), 1);
        check_writes("fbad", base, 2);
        base = wa.size();
        send_bytes(good, 0);
        check_boot("boot2");
        check_writes("f2", base, 2);
        check("f2_starts", 32'(start_cnt), 2);

        // Zero-length image
        base = wa.size();
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        check_boot("boot0");
        check("z_nowrite", 32'(wa.size() - base), 0);
        check("z_starts", 32'(start_cnt), 3);

        // Count one past capacity, then stray bytes while in error
        send_bytes('{8'hA5, 8'h01, 8'h10}, 0);
        idle();
        check("big_err", 32'(bus.error), 1);
        check("big_busy", 32'(bus.busy), 0);
        check("big_corerst", 32'(bus.core_reset), 1);
        send_bytes('{8'h12, 8'h00}, 0);
        idle();
        check("big_hold", 32'(bus.error), 1);

        // Leading garbage and random valid gaps
        base = wa.size();
        send_bytes('{8'h00, 8'hFF, 8'h12}, 1);
        send_bytes(good, 1);
        check_boot("boot3");
        check_writes("f3", base, 2);
        check("f3_starts", 32'(start_cnt), 4);

        // Reset after six payload bytes
        base = wa.size();
        send_bytes(part, 0);
        @(negedge clock);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_vals("midrst");
        repeat (2) idle();
        check_writes("fmid", base, 1);
        check("mid_starts", 32'(start_cnt), 4);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
